dmem_pipe: RTL
==============

Name: dmem_pipe

Overview:
- Parametrised, pipelined successor of the core data memory.
- Word-organised RAM with byte-lane stores at the true byte offset and offset-aware load extraction with sign/zero extension.
- Valid/ready request handshake, fixed-latency response, misalignment flagging, and a post-reset clear FSM replacing single-cycle array reset.
- Sits behind the LSU in the MEM stage.

Parameters:
- DEPTH_WORDS, 8192, number of 32-bit words; power of two, ≥ 4; IDX_W = log2(DEPTH_WORDS).
- READ_LAT, 1, response latency in cycles after accept; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = zero all words after reset via the clear FSM; 0 = contents undefined, ready immediately.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request this cycle.
- i_addr  in  32  byte address.
- i_wren  in  1  1 = store request, 0 = load request.
- i_lsu_op  in  4  loads: 0000 LB, 0001 LBU, 0010 LH, 0011 LHU, 0100 LW; stores: 1000 SB, 1001 SH, 1010 SW.
- i_wdata  in  32  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle pulse per accepted request.
- o_rdata  out  32  load result; 0 for stores, illegal ops and misaligned accesses.
- o_misalign  out  1  qualifies o_rsp_valid: access was misaligned.
- o_illegal  out  1  qualifies o_rsp_valid: op/wren combination not legal.
- o_busy  out  1  clear FSM active.

Behaviour:
- Async reset values: o_req_ready=0, o_rsp_valid=0, o_rdata=0, o_misalign=0, o_illegal=0, o_busy=CLEAR_ON_RESET. In-flight responses are discarded. The array is not reset asynchronously.
- FSM states are CLEAR and READY.
  - Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR writes 0 to word cnt each cycle, cnt running 0..DEPTH_WORDS-1; on the last word, transition to READY. Exactly DEPTH_WORDS cycles with o_busy=1 and o_req_ready=0.
  - READY: o_req_ready=1 constantly; no response backpressure.
  - Reset asserted mid-CLEAR or mid-traffic restarts CLEAR from cnt=0.
- Accept = i_req_valid & o_req_ready. At most one request per cycle.
- Addressing:
  - Word index = i_addr[IDX_W+1:2], offset = i_addr[1:0].
  - Bits above IDX_W+1 are ignored (aliasing wrap); address DEPTH_WORDS*4 maps to word 0.
- Legality:
  - A store requires i_wren=1 with op in {1000, 1001, 1010}.
  - A load requires i_wren=0 with op in {0000..0100}.
  - Any other combination: o_illegal=1, no write, o_rdata=0.
- Misalignment:
  - Half-word access with offset[0]=1, or word access with offset≠0: o_misalign=1, no write, o_rdata=0.
  - Byte accesses are never misaligned.
  - Illegal takes precedence over misalign.
- Stores (written at the accept edge):
  - SB writes lane offset with i_wdata[7:0].
  - SH writes lanes offset..offset+1 with i_wdata[15:0].
  - SW writes all four lanes.
  - Unaddressed lanes are preserved.
- Loads:
  - Word read at the accept edge (synchronous read).
  - Byte/half selected by offset; LB/LH sign-extend, LBU/LHU zero-extend.
- Latency:
  - o_rsp_valid asserts exactly READ_LAT cycles after the accept edge, for all request kinds.
  - With READ_LAT=2, extraction and extension happen in stage 2 and back-to-back requests pipeline fully.
- Hazards:
  - A load accepted the cycle after a store to the same word returns the stored data.
  - The response pipeline holds its last o_rdata when o_rsp_valid=0 (no clearing required between responses).

Decomposition:
- Package dmem_pkg:
  - lsu_op_e enum with the eight encodings.
  - Constants LANE_W=8, NUM_LANES=4.
  - Function lane_mask(op, offset) returning a 4-bit lane enable.
  - Function load_extract(op, offset, word) returning 32 bits.
- Sub-module dmem_ram_bytelane: DEPTH_WORDS × 4 byte lanes, one write port with 4-bit lane enable and one synchronous read port.
- The FSM, legality checks and response pipeline stay in dmem_pipe.

Test Plan:
- Clear: DEPTH_WORDS=16, pulse i_reset → o_busy=1 and o_req_ready=0 for exactly 16 cycles; LW from every word then returns 0x00000000.
- Byte lanes: SW 0x11223344 @0x8; SB 0xAA @0xA; SH 0xBEEF @0xC → LW @0x8 returns 0x11AA3344; LW @0xC returns 0x0000BEEF.
- Extension: word @0x4 = 0x80F17F01 → LB @0x6 returns 0xFFFFFFF1, LBU @0x6 returns 0x000000F1, LH @0x6 returns 0xFFFF80F1, LHU @0x4 returns 0x00007F01.
- Misalign/illegal: LW @0x2 gives rsp with o_misalign=1, o_rdata=0; SH @0x1 gives o_misalign=1 and memory unchanged; i_wren=1 with op 0100 gives o_illegal=1.
- Latency/pipelining, READ_LAT=2: four back-to-back loads → four consecutive o_rsp_valid pulses starting 2 cycles after the first accept, data in request order; store-then-load to the same word on adjacent cycles returns the new data.
- Reset mid-operation: assert i_reset while a response is in flight and while cnt=7 in CLEAR → no o_rsp_valid is emitted; clear restarts and lasts a full 16 cycles; wrap check: LW @0x40 aliases word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the pipelined data memory.
// Op encodings match the LSU's i_lsu_op field.
package dmem_pkg;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LBU = 4'b0001,
    OP_LH  = 4'b0010,
    OP_LHU = 4'b0011,
    OP_LW  = 4'b0100,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } lsu_op_e;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  function automatic logic [NUM_LANES-1:0] lane_mask(input lsu_op_e op, input logic [1:0] offset);
    case (op)
      OP_SB:   lane_mask = 4'b0001 << offset;
      OP_SH:   lane_mask = 4'b0011 << offset;
      OP_SW:   lane_mask = '1;
      default: lane_mask = '0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input lsu_op_e op, input logic [1:0] offset,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[offset*LANE_W +: LANE_W];
    h = offset[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'h0, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'h0, h};
      OP_LW:   load_extract = word;
      default: load_extract = '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_bytelane.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module dmem_ram_bytelane
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned IDX_W       = 13
) (
  input  logic                 i_clk,
  input  logic [NUM_LANES-1:0] i_we,
  input  logic [IDX_W-1:0]     i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic                 i_re,
  input  logic [IDX_W-1:0]     i_raddr,
  output logic [31:0]          o_rdata
);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (i_we[l]) mem[i_waddr][l] <= i_wdata[l*LANE_W +: LANE_W];
    end
    if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined data memory: valid/ready requests, fixed-latency responses,
// byte-lane stores, extending loads and a post-reset clear sweep.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 8192,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_addr,
  input  logic        i_wren,
  input  logic [3:0]  i_lsu_op,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal,
  output logic        o_busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e           state, state_nx;
  logic [IDX_W-1:0] cnt;
  logic             clearing;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ST_CLEAR) ? cnt + IDX_W'(1) : '0;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == ST_CLEAR && cnt == IDX_W'(DEPTH_WORDS - 1)) state_nx = ST_READY;
  end

  // ready is held low while reset is asserted even when no clear sweep follows
  always_comb begin
    clearing    = (state == ST_CLEAR);
    o_busy      = (state == ST_CLEAR);
    o_req_ready = (state == ST_READY) && !i_reset;
  end

  lsu_op_e          op;
  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic             accept, illegal, misalign, do_store, do_load;
  logic             unused_addr;

  always_comb begin
    op       = lsu_op_e'(i_lsu_op);
    off      = i_addr[1:0];
    idx      = i_addr[IDX_W+1:2];
    accept   = i_req_valid && o_req_ready;
    illegal  = i_wren ? !(op inside {OP_SB, OP_SH, OP_SW})
                      : !(op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW});
    misalign = !illegal &&
               (((op inside {OP_LH, OP_LHU, OP_SH}) && off[0]) ||
                ((op inside {OP_LW, OP_SW}) && off != 2'b00));
    do_store = accept && i_wren && !illegal && !misalign;
    do_load  = accept && !i_wren && !illegal && !misalign;
  end

  assign unused_addr = ^i_addr[31:IDX_W+2];

  logic [NUM_LANES-1:0] ram_we;
  logic [IDX_W-1:0]     ram_waddr;
  logic [31:0]          ram_wdata, ram_q;

  always_comb begin
    ram_we    = '0;
    ram_waddr = idx;
    case (op)
      OP_SB:   ram_wdata = {NUM_LANES{i_wdata[7:0]}};
      OP_SH:   ram_wdata = {2{i_wdata[15:0]}};
      default: ram_wdata = i_wdata;
    endcase
    if (clearing) begin
      ram_we    = '1;
      ram_waddr = cnt;
      ram_wdata = '0;
    end else if (do_store) begin
      ram_we = lane_mask(op, off);
    end
  end

  dmem_ram_bytelane #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (ram_we),
    .i_waddr(ram_waddr),
    .i_wdata(ram_wdata),
    .i_re   (do_load),
    .i_raddr(idx),
    .o_rdata(ram_q)
  );

  // s1_zero forces 0 for stores/faults and masks the un-reset RAM read register
  logic       s1_valid, s1_zero, s1_mis, s1_ill;
  lsu_op_e    s1_op;
  logic [1:0] s1_off;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b1;
      s1_mis   <= 1'b0;
      s1_ill   <= 1'b0;
      s1_op    <= OP_LB;
      s1_off   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_zero <= !do_load;
        s1_mis  <= misalign;
        s1_ill  <= illegal;
        s1_op   <= op;
        s1_off  <= off;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        o_rsp_valid <= 1'b0;
        o_rdata     <= '0;
        o_misalign  <= 1'b0;
        o_illegal   <= 1'b0;
      end else begin
        o_rsp_valid <= s1_valid;
        if (s1_valid) begin
          o_rdata    <= s1_zero ? '0 : load_extract(s1_op, s1_off, ram_q);
          o_misalign <= s1_mis;
          o_illegal  <= s1_ill;
        end
      end
    end
  end else begin : g_lat1
    always_comb begin
      o_rsp_valid = s1_valid;
      o_rdata     = s1_zero ? '0 : load_extract(s1_op, s1_off, ram_q);
      o_misalign  = s1_mis;
      o_illegal   = s1_ill;
    end
  end

endmodule
